gates_mux_resp_checker: RTL

Response-side checker for the 2:1-mux-based basic-gate block. It samples the gate block's inputs and its seven outputs on a strobe. Each sample is checked against the golden truth table, and the checker accumulates error counts, first-failure data and input-combination coverage. At the end of a sweep it reports a single pass/fail, so gate sweeps are self-checking in simulation and on-chip.

---
 rtl/gates_pkg.sv | 21 ++
 rtl/gates_golden_model.sv | 21 ++
 rtl/gates_mux_resp_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gates_pkg.sv
// Shared types and constants for the 2:1-mux gate block response checker.
// Mismatch/golden vectors use the IDX_* bit order throughout.
package gates_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NUM_GATES = 7;

    localparam int unsigned IDX_AND  = 0;
    localparam int unsigned IDX_OR   = 1;
    localparam int unsigned IDX_NOT  = 2;
    localparam int unsigned IDX_XOR  = 3;
    localparam int unsigned IDX_XNOR = 4;
    localparam int unsigned IDX_NAND = 5;
    localparam int unsigned IDX_NOR  = 6;

endpackage

// File: rtl/gates_golden_model.sv
// Combinational truth table for the seven basic gates, packed in mismatch bit order.
module gates_golden_model
    import gates_pkg::*;
(
    input  logic                 a_i,
    input  logic                 b_i,
    output logic [NUM_GATES-1:0] exp_o
);

    always_comb begin
        exp_o           = '0;
        exp_o[IDX_AND]  = a_i & b_i;
        exp_o[IDX_OR]   = a_i | b_i;
        exp_o[IDX_NOT]  = ~a_i;
        exp_o[IDX_XOR]  = a_i ^ b_i;
        exp_o[IDX_XNOR] = ~(a_i ^ b_i);
        exp_o[IDX_NAND] = ~(a_i & b_i);
        exp_o[IDX_NOR]  = ~(a_i | b_i);
    end

endmodule

// File: rtl/gates_mux_resp_checker.sv
// Samples gate-block outputs on a strobe, checks them against the golden table and
// accumulates errors, first-failure data and input coverage over a run of NUM_VEC samples.
module gates_mux_resp_checker
    import gates_pkg::*;
#(
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 smp_valid_i,
    input  logic                 a_i,
    input  logic                 b_i,
    input  logic                 c_and_i,
    input  logic                 c_or_i,
    input  logic                 c_not_i,
    input  logic                 c_xor_i,
    input  logic                 c_xnor_i,
    input  logic                 c_nand_i,
    input  logic                 c_nor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNT_W-1:0]     vec_cnt_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [CNT_W-1:0]     first_err_idx_o,
    output logic [NUM_GATES-1:0] first_err_mask_o,
    output logic [3:0]           cov_seen_o
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     first_err_idx_q, first_err_idx_d;
    logic [NUM_GATES-1:0] first_err_mask_q, first_err_mask_d;
    logic [3:0]           cov_seen_q, cov_seen_d;
    logic                 pass_q, pass_d;

    logic [NUM_GATES-1:0] golden;
    logic [NUM_GATES-1:0] observed;
    logic [NUM_GATES-1:0] mismatch;

    gates_golden_model u_golden (
        .a_i   (a_i),
        .b_i   (b_i),
        .exp_o (golden)
    );

    assign observed = {c_nor_i, c_nand_i, c_xnor_i, c_xor_i, c_not_i, c_or_i, c_and_i};
    assign mismatch = observed ^ golden;

    always_comb begin
        state_d          = state_q;
        vec_cnt_d        = vec_cnt_q;
        err_cnt_d        = err_cnt_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_mask_d = first_err_mask_q;
        cov_seen_d       = cov_seen_q;
        pass_d           = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                // A coincident strobe is dropped: start takes priority.
                if (start_i) begin
                    state_d          = StRun;
                    vec_cnt_d        = '0;
                    err_cnt_d        = '0;
                    first_err_idx_d  = '0;
                    first_err_mask_d = '0;
                    cov_seen_d       = '0;
                    pass_d           = 1'b0;
                end
            end
            StRun: begin
                if (smp_valid_i) begin
                    if (mismatch != '0) begin
                        if (err_cnt_q == '0) begin
                            first_err_idx_d  = vec_cnt_q;
                            first_err_mask_d = mismatch;
                        end
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                    cov_seen_d = cov_seen_q | (4'b0001 << {a_i, b_i});
                    vec_cnt_d  = vec_cnt_q + CNT_W'(1);
                    if (vec_cnt_q == LastIdx) begin
                        state_d = StDone;
                        pass_d  = (err_cnt_d == '0) && (cov_seen_d == 4'b1111);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            vec_cnt_q        <= '0;
            err_cnt_q        <= '0;
            first_err_idx_q  <= '0;
            first_err_mask_q <= '0;
            cov_seen_q       <= '0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_cnt_q        <= vec_cnt_d;
            err_cnt_q        <= err_cnt_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_mask_q <= first_err_mask_d;
            cov_seen_q       <= cov_seen_d;
            pass_q           <= pass_d;
        end
    end

    assign busy_o           = (state_q == StRun);
    assign done_o           = (state_q == StDone);
    assign pass_o           = pass_q;
    assign vec_cnt_o        = vec_cnt_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_idx_o  = first_err_idx_q;
    assign first_err_mask_o = first_err_mask_q;
    assign cov_seen_o       = cov_seen_q;

endmodule
